// File: rtl/neuron_wxor_mc.sv
// -----------------------------------------------------------------------------
// neuron_wxor_mc
//   Multi-channel wxor neuron. It evaluates one neuron over WINDOW time-steps.
//   Each step delivers N_IN tac pulses and input signs. Every active channel
//   adds its weight or subtracts it, chosen by sign_x ^ sign_w, into a signed
//   saturating accumulator that is preloaded with a signed bias. Channels are
//   processed serially, one per clock, so a single adder is shared.
//
//   Optional feature (macro NEURON_RELU_EN):
//     defined   : a negative final result is written to dout as 0
//     undefined : dout carries the saturated signed result
//
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous, active-low reset
//     start       begin an evaluation (only honoured in IDLE)
//     bias        bias magnitude, sampled with start
//     bias_sign   1 = negative bias, sampled with start
//     step_valid  tac_in / sign_x valid this cycle
//     step_ready  block accepts a step this cycle
//     tac_in      per-channel pulse for the current step
//     sign_x      per-channel input sign
//     sign_w      per-channel weight sign (must be held stable while busy)
//     win         weights, channel i at [i*W_WIDTH +: W_WIDTH] (held while busy)
//     dout        signed result, held until the next result
//     dout_valid  one-cycle pulse when dout updates
//     busy        high in any state other than IDLE
// -----------------------------------------------------------------------------
module neuron_wxor_mc #(
   parameter int N_IN      = 4,
   parameter int W_WIDTH   = 8,
   parameter int ACC_WIDTH = 12,
   parameter int WINDOW    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [W_WIDTH-1:0]        bias,
   input  logic                      bias_sign,
   input  logic                      step_valid,
   output logic                      step_ready,
   input  logic [N_IN-1:0]           tac_in,
   input  logic [N_IN-1:0]           sign_x,
   input  logic [N_IN-1:0]           sign_w,
   input  logic [N_IN*W_WIDTH-1:0]   win,
   output logic [ACC_WIDTH-1:0]      dout,
   output logic                      dout_valid,
   output logic                      busy
);

   localparam int CH_W = (N_IN   > 1) ? $clog2(N_IN)   : 1;
   localparam int SC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_IN - 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(WINDOW - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_STEP,
      S_ACCUM
   } state_t;

   state_t                 r_state;
   state_t                 w_next;

   logic [ACC_WIDTH-1:0]   r_acc;
   logic [SC_W-1:0]        r_step_cnt;
   logic [CH_W-1:0]        r_ch;
   logic [N_IN-1:0]        r_tac;
   logic [N_IN-1:0]        r_sx;
   logic [ACC_WIDTH-1:0]   r_dout;
   logic                   r_dout_valid;

   logic [W_WIDTH-1:0]     w_wsel;
   logic                   w_tac;
   logic                   w_sx;
   logic                   w_sw;
   logic [ACC_WIDTH:0]     w_mag_ext;
   logic [ACC_WIDTH:0]     w_term;
   logic [ACC_WIDTH:0]     w_sum;
   logic [ACC_WIDTH-1:0]   w_sat;
   logic [ACC_WIDTH-1:0]   w_out;
   logic [ACC_WIDTH-1:0]   w_bias_ext;
   logic [ACC_WIDTH-1:0]   w_preload;
   logic                   w_last_ch;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   assign w_last_ch = (r_ch == CH_LAST);

   always_comb begin
      w_next     = r_state;
      step_ready = 1'b0;
      busy       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_WAIT_STEP;
         end
         S_WAIT_STEP: begin
            step_ready = 1'b1;
            if (step_valid) w_next = S_ACCUM;
         end
         S_ACCUM: begin
            if (w_last_ch) begin
               if (r_step_cnt < SC_LAST) w_next = S_WAIT_STEP;
               else                      w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------- channel mux
   always_comb begin
      w_wsel = '0;
      w_tac  = 1'b0;
      w_sx   = 1'b0;
      w_sw   = 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (r_ch == CH_W'(i)) begin
            w_wsel = win[i*W_WIDTH +: W_WIDTH];
            w_tac  = r_tac[i];
            w_sx   = r_sx[i];
            w_sw   = sign_w[i];
         end
      end
   end

   // ------------------------------------------------- saturating adder
   // The sum is formed one bit wider than the accumulator; the weight
   // magnitude is far below the accumulator range, so the extra bit
   // always holds the true sign and overflow is a simple top-two-bit compare.
   always_comb begin
      w_mag_ext = {{(ACC_WIDTH + 1 - W_WIDTH){1'b0}}, w_wsel};
      if (!w_tac)            w_term = '0;
      else if (w_sx ^ w_sw)  w_term = -w_mag_ext;
      else                   w_term = w_mag_ext;
      w_sum = {r_acc[ACC_WIDTH-1], r_acc} + w_term;
      if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
         w_sat = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         w_sat = w_sum[ACC_WIDTH-1:0];
      end
   end

`ifdef NEURON_RELU_EN
   assign w_out = w_sat[ACC_WIDTH-1] ? '0 : w_sat;
`else
   assign w_out = w_sat;
`endif

   assign w_bias_ext = {{(ACC_WIDTH - W_WIDTH){1'b0}}, bias};
   assign w_preload  = bias_sign ? -w_bias_ext : w_bias_ext;

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc        <= '0;
         r_step_cnt   <= '0;
         r_ch         <= '0;
         r_tac        <= '0;
         r_sx         <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc      <= w_preload;
                  r_step_cnt <= '0;
               end
            end
            S_WAIT_STEP: begin
               if (step_valid) begin
                  r_tac <= tac_in;
                  r_sx  <= sign_x;
                  r_ch  <= '0;
               end
            end
            S_ACCUM: begin
               r_acc <= w_sat;
               if (w_last_ch) begin
                  if (r_step_cnt < SC_LAST) begin
                     r_step_cnt <= r_step_cnt + SC_W'(1);
                  end else begin
                     r_dout       <= w_out;
                     r_dout_valid <= 1'b1;
                  end
               end else begin
                  r_ch <= r_ch + CH_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_neuron_wxor_mc.sv
// -----------------------------------------------------------------------------
// tb_neuron_wxor_mc
//   Self-checking bench for neuron_wxor_mc: a table of directed evaluations,
//   hand-written reset / back-to-back sequences, and randomized evaluations
//   checked against a behavioural model of the neuron.
// -----------------------------------------------------------------------------
module tb_neuron_wxor_mc;

   localparam int N_IN      = 4;
   localparam int W_WIDTH   = 8;
   localparam int ACC_WIDTH = 12;
   localparam int WINDOW    = 4;
   localparam int AMAX      = (2 ** (ACC_WIDTH - 1)) - 1;
   localparam int AMIN      = -(2 ** (ACC_WIDTH - 1));
   localparam int BASE_LAT  = WINDOW * (N_IN + 1);

   logic                     clk;
   logic                     rst;
   logic                     start;
   logic [W_WIDTH-1:0]       bias;
   logic                     bias_sign;
   logic                     step_valid;
   logic                     step_ready;
   logic [N_IN-1:0]          tac_in;
   logic [N_IN-1:0]          sign_x;
   logic [N_IN-1:0]          sign_w;
   logic [N_IN*W_WIDTH-1:0]  win;
   logic [ACC_WIDTH-1:0]     dout;
   logic                     dout_valid;
   logic                     busy;

   neuron_wxor_mc #(
      .N_IN      (N_IN),
      .W_WIDTH   (W_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .WINDOW    (WINDOW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bias       (bias),
      .bias_sign  (bias_sign),
      .step_valid (step_valid),
      .step_ready (step_ready),
      .tac_in     (tac_in),
      .sign_x     (sign_x),
      .sign_w     (sign_w),
      .win        (win),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Neuron rules: signed bias preload, then per active channel +/- weight
   // with clamping to the signed accumulator range after every addition.
   function automatic int model(input int b, input bit bs,
                                input logic [N_IN*W_WIDTH-1:0] w,
                                input logic [N_IN-1:0] sw,
                                input logic [WINDOW*N_IN-1:0] tacs,
                                input logic [WINDOW*N_IN-1:0] sxs);
      int acc;
      int m;
      acc = bs ? -b : b;
      for (int s = 0; s < WINDOW; s++) begin
         for (int c = 0; c < N_IN; c++) begin
            if (tacs[s*N_IN + c]) begin
               m = int'(w[c*W_WIDTH +: W_WIDTH]);
               acc = (sxs[s*N_IN + c] ^ sw[c]) ? acc - m : acc + m;
               if (acc > AMAX) acc = AMAX;
               if (acc < AMIN) acc = AMIN;
            end
         end
      end
`ifdef NEURON_RELU_EN
      if (acc < 0) acc = 0;
`endif
      return acc;
   endfunction

   // Called at a negedge with the DUT in IDLE; returns at the negedge where
   // dout_valid is seen high, so consecutive calls are back-to-back.
   task automatic run(input string tag, input int b, input bit bs,
                      input logic [N_IN*W_WIDTH-1:0] w,
                      input logic [N_IN-1:0] sw,
                      input logic [WINDOW*N_IN-1:0] tacs,
                      input logic [WINDOW*N_IN-1:0] sxs,
                      input int gap, input bit ms,
                      input int exp_d, input int exp_lat);
      int edges;
      int s;
      int g;
      bit done;
      bit accepted;
      bit rdy_bad;
      logic signed [ACC_WIDTH-1:0] ds;
      bias       = W_WIDTH'(b);
      bias_sign  = bs;
      win        = w;
      sign_w     = sw;
      start      = 1'b1;
      step_valid = 1'b0;
      @(negedge clk);
      start   = 1'b0;
      edges   = 1;
      s       = 0;
      g       = 0;
      done    = 1'b0;
      rdy_bad = 1'b0;
      check({tag, "_dv_clear"}, int'(dout_valid), 0);
      check({tag, "_busy_rise"}, int'(busy), 1);
      while (!done && edges < 400) begin
         if (dout_valid) begin
            done = 1'b1;
         end else begin
            start = ms && (edges == 8);
            if (start) begin
               bias      = '1;
               bias_sign = 1'b0;
            end
            if (s < WINDOW && step_ready && g >= gap) begin
               step_valid = 1'b1;
               tac_in     = tacs[s*N_IN +: N_IN];
               sign_x     = sxs[s*N_IN +: N_IN];
            end else begin
               step_valid = 1'b0;
            end
            accepted = step_valid && step_ready;
            if (step_ready && !step_valid) g++;
            @(negedge clk);
            edges++;
            if (accepted) begin
               s++;
               g = 0;
               if (step_ready) rdy_bad = 1'b1;
            end
         end
      end
      step_valid = 1'b0;
      start      = 1'b0;
      check({tag, "_completed"}, int'(done), 1);
      ds = dout;
      check({tag, "_dout"}, int'(ds), exp_d);
      if (exp_lat >= 0) check({tag, "_latency"}, edges - 1, exp_lat);
      check({tag, "_busy_fall"}, int'(busy), 0);
      check({tag, "_ready_in_accum"}, int'(rdy_bad), 0);
   endtask

   typedef struct {
      string             tag;
      int                b;
      bit                bs;
      logic [31:0]       w;
      logic [3:0]        sx;
      logic [3:0]        sw;
      logic [3:0]        tac;
      int                gap;
      bit                ms;
      int                exp_d;
      int                exp_lat;
   } vec_t;

   vec_t vt[4];
   logic [WINDOW*N_IN-1:0] r_tacs;
   logic [WINDOW*N_IN-1:0] r_sxs;
   logic [N_IN*W_WIDTH-1:0] r_w;
   logic [N_IN-1:0] r_sw;
   int rb;
   bit rbs;
   int rgap;
   int exp3;

   initial begin
`ifdef NEURON_RELU_EN
      exp3 = 0;
`else
      exp3 = -2048;
`endif
      vt[0] = '{"pos_acc",  100, 1'b0, {8'd40, 8'd30, 8'd20, 8'd10}, 4'b1111, 4'b1111, 4'b1111, 0, 1'b0, 500,  BASE_LAT};
      vt[1] = '{"pos_sat",  255, 1'b0, {4{8'd255}},                   4'b0000, 4'b0000, 4'b1111, 0, 1'b0, 2047, BASE_LAT};
      vt[2] = '{"neg_sat",  0,   1'b0, {4{8'd200}},                   4'b1111, 4'b0000, 4'b1111, 0, 1'b0, exp3, BASE_LAT};
      vt[3] = '{"sparse_bp",10,  1'b1, {8'd8, 8'd6, 8'd4, 8'd2},      4'b0000, 4'b0000, 4'b0101, 3, 1'b1, 22,   BASE_LAT + 3*WINDOW};

      rst        = 1'b0;
      start      = 1'b0;
      bias       = '0;
      bias_sign  = 1'b0;
      step_valid = 1'b0;
      tac_in     = '0;
      sign_x     = '0;
      sign_w     = '0;
      win        = '0;
      repeat (3) @(negedge clk);
      check("reset_busy",  int'(busy), 0);
      check("reset_ready", int'(step_ready), 0);
      check("reset_dout",  int'(dout), 0);
      check("reset_dv",    int'(dout_valid), 0);
      rst = 1'b1;
      @(negedge clk);

      // Directed table, applied back-to-back
      for (int i = 0; i < 4; i++) begin
         run(vt[i].tag, vt[i].b, vt[i].bs, vt[i].w, vt[i].sw,
             {WINDOW{vt[i].tac}}, {WINDOW{vt[i].sx}},
             vt[i].gap, vt[i].ms, vt[i].exp_d, vt[i].exp_lat);
      end

      // Reset during ACCUM of the second step
      bias = 8'd100; bias_sign = 1'b0; win = vt[0].w; sign_w = 4'b1111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; step_valid = 1'b1; tac_in = 4'b1111; sign_x = 4'b1111;
      repeat (6) @(negedge clk);
      check("midrst_busy_before", int'(busy), 1);
      check("midrst_ready_before", int'(step_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; step_valid = 1'b0;
      check("midrst_busy",  int'(busy), 0);
      check("midrst_dout",  int'(dout), 0);
      check("midrst_dv",    int'(dout_valid), 0);
      check("midrst_ready", int'(step_ready), 0);
      @(negedge clk);
      run("after_rst", 100, 1'b0, vt[0].w, 4'b1111, {WINDOW{4'b1111}},
          {WINDOW{4'b1111}}, 0, 1'b0, 500, BASE_LAT);

      // Zero case followed immediately by a second start
      run("zero", 0, 1'b0, '0, 4'b0000, {WINDOW{4'b1111}},
          {WINDOW{4'b0000}}, 0, 1'b0, 0, BASE_LAT);
      run("b2b", 100, 1'b0, vt[0].w, 4'b1111, {WINDOW{4'b1111}},
          {WINDOW{4'b1111}}, 0, 1'b0, 500, BASE_LAT);

      // Randomized evaluations against the model
      for (int k = 0; k < 25; k++) begin
         rb     = int'($urandom_range(0, 255));
         rbs    = 1'($urandom);
         r_w    = $urandom;
         r_sw   = N_IN'($urandom);
         r_tacs = (WINDOW*N_IN)'($urandom);
         r_sxs  = (WINDOW*N_IN)'($urandom);
         rgap   = int'($urandom_range(0, 2));
         run($sformatf("rand%0d", k), rb, rbs, r_w, r_sw, r_tacs, r_sxs,
             rgap, 1'b0, model(rb, rbs, r_w, r_sw, r_tacs, r_sxs),
             BASE_LAT + rgap*WINDOW);
      end

      @(negedge clk);
      check("final_dv_clear", int'(dout_valid), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
